seq_encoder_16x4: RTL and testbench
===================================

Name: seq_encoder_16x4

Overview:
Sequential 16-to-4 multi-hot encoder, the inverse of the 4x16 one-hot decoder. It accepts a 16-bit request vector, stores it, and emits the index of every set bit, lowest first, one index per accepted handshake. It sits upstream of the dec_4x16 path: it serialises flag/interrupt vectors into binary indices for the datapath.

Parameters:
WIDTH, 16, request vector width; must equal 2**IDX_W.
IDX_W, 4, index width.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
req_valid  input  1  request vector valid.
req_ready  output  1  block can accept a vector; high only in IDLE.
req_vec  input  WIDTH  multi-hot request vector.
idx_valid  output  1  idx holds a valid index.
idx_ready  input  1  consumer accepts idx.
idx  output  IDX_W  binary index of the lowest pending bit.
idx_last  output  1  idx is the final pending bit of the current vector.
zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded.
busy  output  1  high in EMIT.

Behaviour:
- Reset: sampled on clk edge while rst_n=0. It takes priority over all other inputs. After reset: state=IDLE, pend=0, idx_valid=0, idx=0, idx_last=0, zero_drop=0, busy=0, req_ready=1.
- Reset mid-EMIT: pend is discarded. No further idx_valid until a new vector is accepted.
- FSM has two states, IDLE and EMIT.
- IDLE:
  - req_ready=1.
  - On req_valid=1 with req_vec!=0: pend<=req_vec; state<=EMIT.
  - On req_valid=1 with req_vec==0: vector is accepted; zero_drop=1 for the next cycle only; state stays IDLE.
- EMIT:
  - req_ready=0. req_valid and req_vec are ignored; changing req_vec has no effect.
  - idx_valid=1.
  - idx = position of the lowest set bit of pend.
  - idx_last=1 iff pend has exactly one bit set.
  - On idx_valid&&idx_ready: clear bit idx of pend. If idx_last=1, state<=IDLE and idx_valid=0 next cycle.
- Outputs idx_valid, idx, idx_last, zero_drop and busy are registered, so there is no combinational path from inputs to outputs. req_ready is decoded from state only.
- Latency: vector accepted at edge N gives the first idx_valid in cycle N+1.
- Throughput: one index per cycle while idx_ready=1.
- There is one IDLE bubble cycle between the last index and the next accept.
- Stall: while idx_valid=1 and idx_ready=0, idx, idx_last and pend are held stable.
- Priority is strictly lowest index first. Bit WIDTH-1 always comes last.
- Index 0 is legal: idx=0 with idx_valid=1 is distinct from idle.
- Invariant: the number of indices emitted per vector equals popcount(req_vec).
- No X on any output after reset, including when idx_valid=0.

Test Plan:
1. rst_n=0 for 2 cycles with random inputs -> idx_valid=0, idx=0, idx_last=0, busy=0, zero_drop=0, req_ready=1.
2. req_vec=16'h8421, idx_ready held 1 -> idx=0,5,10,15 on four consecutive cycles; idx_last=1 only with 15; req_ready=1 on the following cycle.
3. req_vec=16'h0006, idx_ready=0 for 3 cycles, then 1 -> idx=1 held stable for 3 cycles; then idx=1 accepted, followed by idx=2 with idx_last=1.
4. req_vec=16'h0000 with req_valid=1 -> zero_drop=1 for exactly one cycle; idx_valid stays 0; req_ready stays 1.
5. req_vec=16'h8000 accepted, then req_valid=1 with req_vec=16'h0001 during EMIT -> single idx=15 with idx_last=1; the second vector is not taken (req_ready=0); it is accepted after return to IDLE and emits idx=0.
6. req_vec=16'hFFFF, rst_n=0 after 3 handshakes -> next cycle idx_valid=0 and busy=0; a following vector 16'h0010 emits only idx=4.

Source files
------------

// File: rtl/seq_encoder_16x4.sv
// Sequential multi-hot encoder: accepts a request vector and emits the index of each
// set bit, lowest first, one index per idx_valid/idx_ready handshake.
module seq_encoder_16x4 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_vec,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    output logic             zero_drop,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_pend;
    logic             r_idx_valid;
    logic [IDX_W-1:0] r_idx;
    logic             r_idx_last;
    logic             r_zero_drop;
    logic             r_busy;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_pend_nxt;
    logic             w_zero_drop_nxt;
    logic             w_hs;
    logic [WIDTH-1:0] w_idx_mask;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_last_nxt;

    assign w_hs       = r_idx_valid && idx_ready;
    assign w_idx_mask = WIDTH'(1) << r_idx;

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_nxt      = r_pend;
        w_zero_drop_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_vec == '0) begin
                        w_zero_drop_nxt = 1'b1;
                    end else begin
                        w_pend_nxt  = req_vec;
                        w_state_nxt = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (w_hs) begin
                    w_pend_nxt = r_pend & ~w_idx_mask;
                    if (r_idx_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pend_nxt  = '0;
            end
        endcase
    end

    // Index and last flag are precomputed from the next pending set so they can be registered.
    always_comb begin
        w_idx_nxt = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_pend_nxt[i]) begin
                w_idx_nxt = IDX_W'(i);
            end
        end
        w_last_nxt = (w_pend_nxt != '0) && ((w_pend_nxt & (w_pend_nxt - WIDTH'(1))) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pend      <= '0;
            r_idx_valid <= 1'b0;
            r_idx       <= '0;
            r_idx_last  <= 1'b0;
            r_zero_drop <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_idx_valid <= (w_state_nxt == ST_EMIT);
            r_idx       <= w_idx_nxt;
            r_idx_last  <= w_last_nxt;
            r_zero_drop <= w_zero_drop_nxt;
            r_busy      <= (w_state_nxt == ST_EMIT);
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign idx_valid = r_idx_valid;
    assign idx       = r_idx;
    assign idx_last  = r_idx_last;
    assign zero_drop = r_zero_drop;
    assign busy      = r_busy;

endmodule

// File: tb/tb_seq_encoder_16x4.sv
// Randomised self-checking bench for seq_encoder_16x4 against a queue-of-indices model.
module tb_seq_encoder_16x4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_vec;
    logic        idx_valid;
    logic        idx_ready;
    logic [3:0]  idx;
    logic        idx_last;
    logic        zero_drop;
    logic        busy;

    int n_vec;
    int n_err;

    // Model: pending indices in emission order; empty queue means idle.
    int m_q[$];
    bit m_zd;

    seq_encoder_16x4 #(
        .WIDTH (16),
        .IDX_W (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_vec   (req_vec),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx       (idx),
        .idx_last  (idx_last),
        .zero_drop (zero_drop),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_zd = 1'b0;
        end else if (m_q.size() == 0) begin
            m_zd = req_valid && (req_vec == 16'h0000);
            if (req_valid) begin
                for (int b = 0; b < 16; b++) begin
                    if (req_vec[b]) m_q.push_back(b);
                end
            end
        end else begin
            m_zd = 1'b0;
            if (idx_ready) void'(m_q.pop_front());
        end
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic cyc(input bit rn, input bit v, input logic [15:0] vec, input bit rdy);
        int sz;
        @(negedge clk);
        sz = m_q.size();
        check_eq("idx_valid", {15'd0, idx_valid}, {15'd0, sz > 0});
        check_eq("idx", {12'd0, idx}, (sz > 0) ? 16'(m_q[0]) : 16'd0);
        check_eq("idx_last", {15'd0, idx_last}, {15'd0, sz == 1});
        check_eq("zero_drop", {15'd0, zero_drop}, {15'd0, m_zd});
        check_eq("busy", {15'd0, busy}, {15'd0, sz > 0});
        check_eq("req_ready", {15'd0, req_ready}, {15'd0, sz == 0});
        rst_n     = rn;
        req_valid = v;
        req_vec   = vec;
        idx_ready = rdy;
    endtask

    function automatic logic [15:0] rnd_vec();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'(1 << $urandom_range(0, 15));
            2:       return 16'($urandom) & 16'($urandom);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_zd      = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'($urandom);
        req_vec   = 16'($urandom);
        idx_ready = 1'($urandom);

        // Reset with random inputs
        cyc(1'b0, 1'($urandom), 16'($urandom), 1'($urandom));
        cyc(1'b1, 1'b0, 16'($urandom), 1'b1);

        // Spread vector, free-flowing consumer
        cyc(1'b1, 1'b1, 16'h8421, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b1);

        // Stall for three cycles
        cyc(1'b1, 1'b1, 16'h0006, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b1);

        // All-zero vector
        cyc(1'b1, 1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b1);

        // Request held during EMIT is only taken after returning to IDLE
        cyc(1'b1, 1'b1, 16'h8000, 1'b0);
        cyc(1'b1, 1'b1, 16'h0001, 1'b0);
        cyc(1'b1, 1'b1, 16'h0001, 1'b1);
        cyc(1'b1, 1'b1, 16'h0001, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b1);

        // Reset mid-EMIT
        cyc(1'b1, 1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b1);
        cyc(1'b0, 1'b0, 16'($urandom), 1'b1);
        cyc(1'b1, 1'b1, 16'h0010, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b1);

        // Random traffic with rare resets
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) != 0), 1'($urandom), rnd_vec(),
                ($urandom_range(0, 3) != 0));
        end
        cyc(1'b1, 1'b0, 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
